fog_loop_sequencer: RTL
=======================

Name: fog_loop_sequencer

Overview:
Closed-loop sequencer for the gyro modulation/phase-ramp datapath. Once per modulation period (stepTrig), it decides whether the phase-ramp generator runs open-loop or closed-loop and which gain shift it uses, and forwards the demodulated step to the ramp. It drives the ramp's fb_on, gain_sel and step inputs through a startup, coarse-acquire, fine-track and relock sequence, and counts loss-of-lock events.

Parameters:
SETTLE_CNT, 16, number of trigger periods spent open-loop after enable (min 1)
COARSE_CNT, 64, consecutive in-threshold trigger periods required to leave COARSE (min 1)
FAULT_RUN, 8, consecutive over-threshold trigger periods in FINE that declare loss of lock (min 1)
GAIN_COARSE, 4'd6, gain_sel value used in SETTLE, COARSE and RELOCK

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_trig  in  1  one-cycle pulse per modulation period (stepTrig from modulation generator)
i_enable  in  1  loop enable level
i_step_in  in  32  signed demodulated error step
i_gain_fine  in  4  gain_sel value used in FINE
i_err_thresh  in  32  unsigned magnitude threshold for the lock test
o_step  out  32  signed step to phase ramp generator
o_fb_on  out  32  feedback enable to phase ramp; value is 0 or 1
o_gain_sel  out  4  gain select to phase ramp
o_state  out  3  IDLE=0, SETTLE=1, COARSE=2, FINE=3, RELOCK=4
o_locked  out  1  high only in FINE
o_fault_cnt  out  16  count of FINE->RELOCK events, saturates at 16'hFFFF

Behaviour:
- Reset (i_rst=1 at a rising edge): state IDLE; trig counter 0; o_step=0; o_fb_on=0; o_gain_sel=0; o_locked=0; o_fault_cnt=0.
- Priority: i_rst > i_enable low > i_trig.
- i_enable=0 in any non-IDLE state: go to IDLE at the next edge, without waiting for i_trig. Apply IDLE outputs. o_fault_cnt is kept.
- All other state transitions and all output updates happen only on edges where i_trig=1. No gain or fb change occurs mid-period.
- Magnitude: |i_step_in|, two's complement. 32'h80000000 maps to 32'h7FFFFFFF.
  - over = magnitude > i_err_thresh (strict).
- Trigger counter: 16-bit. It is cleared on every state entry.
- IDLE:
  - Outputs 0.
  - Trig with i_enable=1 -> SETTLE.
- SETTLE:
  - o_fb_on=0; o_gain_sel=GAIN_COARSE; o_step=0.
  - Counter increments per trig.
  - Trig with counter==SETTLE_CNT-1 -> COARSE.
- COARSE:
  - o_fb_on=1; o_gain_sel=GAIN_COARSE.
  - Counter counts consecutive triggers with over=0; a trig with over=1 clears it.
  - Trig where the count reaches COARSE_CNT -> FINE.
- FINE:
  - o_fb_on=1; o_gain_sel=i_gain_fine, sampled on each trig; o_locked=1.
  - Counter counts consecutive triggers with over=1; a trig with over=0 clears it.
  - Trig where the count reaches FAULT_RUN -> RELOCK, and o_fault_cnt increments (saturating).
- RELOCK:
  - o_fb_on=1; o_gain_sel=GAIN_COARSE; o_locked=0.
  - Next trig -> COARSE.
- o_step:
  - Registered on each trig edge: i_step_in when the state being entered or held has fb_on=1, else 0.
  - Latency is 1 clock from i_trig. The value holds between triggers.
- Outputs reflect the new state in the same edge as the transition.
- i_trig held high on consecutive cycles: each high cycle is a separate trigger.
- Counters never wrap within a state: the transition fires at the threshold.

Test Plan:
- Reset check: i_rst=1 for 3 clocks, then release with i_enable=0 and i_trig every 100 clks for 5 periods -> all outputs 0, o_state=0.
- Startup: SETTLE_CNT=4, COARSE_CNT=8, i_enable=1, i_step_in=-100, thresh=200 -> SETTLE for 4 trigs with fb_on=0 and step=0; COARSE for 8 trigs with gain=6 and o_step=-100 one clk after each trig; FINE with gain=i_gain_fine=1 and o_locked=1.
- Coarse restart: in COARSE, inject one step=500 (thresh 200) at trig 5 -> count clears; FINE is entered 8 trigs after the glitch.
- Fault: in FINE with FAULT_RUN=3, step=32'h80000000 for 3 trigs -> RELOCK on the 3rd, o_fault_cnt=1, gain=6; next trig -> COARSE. Two bad trigs then one good one -> stays FINE.
- Disable mid-period: drop i_enable 40 clks after a trig in FINE -> IDLE next clk, fb_on=0, step=0, fault_cnt retained; re-enable -> SETTLE on next trig.
- Boundary: step=thresh exactly -> not over. Back-to-back i_trig high for 2 clks in SETTLE with SETTLE_CNT=2 -> COARSE after the second.

Source files
------------

// File: rtl/fog_loop_if.sv
// Sequencer-facing bundle: trigger/enable/error inputs and the
// phase-ramp control outputs.
interface fog_loop_if;
    logic               i_trig;
    logic               i_enable;
    logic signed [31:0] i_step_in;
    logic [3:0]         i_gain_fine;
    logic [31:0]        i_err_thresh;
    logic signed [31:0] o_step;
    logic [31:0]        o_fb_on;
    logic [3:0]         o_gain_sel;
    logic [2:0]         o_state;
    logic               o_locked;
    logic [15:0]        o_fault_cnt;

    modport master (
        output i_trig, i_enable, i_step_in, i_gain_fine, i_err_thresh,
        input  o_step, o_fb_on, o_gain_sel, o_state, o_locked,
        o_fault_cnt
    );

    modport slave (
        input  i_trig, i_enable, i_step_in, i_gain_fine, i_err_thresh,
        output o_step, o_fb_on, o_gain_sel, o_state, o_locked,
        o_fault_cnt
    );
endinterface

// File: rtl/fog_loop_sequencer.sv
// Open/closed-loop sequencer for the gyro phase ramp: settle, coarse
// acquire, fine track and relock, advancing once per modulation period.
module fog_loop_sequencer #(
    parameter int         SETTLE_CNT  = 16,
    parameter int         COARSE_CNT  = 64,
    parameter int         FAULT_RUN   = 8,
    parameter logic [3:0] GAIN_COARSE = 4'd6
) (
    input logic      i_clk,
    input logic      i_rst,
    fog_loop_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        COARSE = 3'd2,
        FINE   = 3'd3,
        RELOCK = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic signed [31:0] step_q, step_d;
    logic [3:0]         gain_q, gain_d;
    logic [15:0]        fault_q, fault_d;

    logic [31:0] mag;
    logic [15:0] cnt_inc;
    logic        over;
    logic        fb_next;

    // Most negative input saturates instead of wrapping back negative.
    always_comb begin
        mag = bus.i_step_in;
        if (bus.i_step_in[31]) begin
            if (bus.i_step_in == 32'sh8000_0000) begin
                mag = 32'h7FFF_FFFF;
            end else begin
                mag = ~bus.i_step_in + 32'd1;
            end
        end
    end

    assign over    = mag > bus.i_err_thresh;
    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        gain_d  = gain_q;
        fault_d = fault_q;
        fb_next = 1'b0;
        if (!bus.i_enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            step_d  = '0;
            gain_d  = '0;
        end else if (bus.i_trig) begin
            unique case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
                SETTLE: begin
                    if (cnt_q == 16'(SETTLE_CNT - 1)) begin
                        state_d = COARSE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                COARSE: begin
                    if (over) begin
                        cnt_d = '0;
                    end else if (cnt_inc == 16'(COARSE_CNT)) begin
                        state_d = FINE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                FINE: begin
                    if (!over) begin
                        cnt_d = '0;
                    end else if (cnt_inc == 16'(FAULT_RUN)) begin
                        state_d = RELOCK;
                        cnt_d   = '0;
                        if (fault_q != 16'hFFFF) begin
                            fault_d = fault_q + 16'd1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                RELOCK: begin
                    state_d = COARSE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase

            // Gain and step follow the state being entered or held.
            unique case (state_d)
                SETTLE: gain_d = GAIN_COARSE;
                COARSE: gain_d = GAIN_COARSE;
                RELOCK: gain_d = GAIN_COARSE;
                FINE:   gain_d = bus.i_gain_fine;
                default: gain_d = '0;
            endcase
            fb_next = (state_d == COARSE) || (state_d == FINE) ||
                      (state_d == RELOCK);
            step_d  = fb_next ? bus.i_step_in : 32'sd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            gain_q  <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            gain_q  <= gain_d;
            fault_q <= fault_d;
        end
    end

    assign bus.o_step      = step_q;
    assign bus.o_gain_sel  = gain_q;
    assign bus.o_state     = state_q;
    assign bus.o_locked    = (state_q == FINE);
    assign bus.o_fault_cnt = fault_q;
    assign bus.o_fb_on     = {31'd0, (state_q == COARSE) ||
                              (state_q == FINE) || (state_q == RELOCK)};

endmodule
